// File: rtl/d_mem_wait_sim.sv
// Simulation data memory for the CPU d_* bus: per-direction wait states, range error flag
// and completed-access counters. The memory array is preloaded at time zero and survives rst.
module d_mem_wait_sim #(
  parameter int                      D_ADDR_WIDTH = 8,
  parameter int                      D_DATA_WIDTH = 8,
  parameter int                      D_MEM_LENGTH = 64,
  parameter int                      RD_WAIT      = 0,
  parameter int                      WR_WAIT      = 0,
  parameter logic [D_DATA_WIDTH-1:0] INIT_VALUE   = '0,
  parameter logic                    DIR_WRITE    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    d_req,
  input  logic                    d_dir,
  input  logic [D_ADDR_WIDTH-1:0] d_addr,
  input  logic [D_DATA_WIDTH-1:0] d_wdata,
  output logic                    d_ack,
  output logic [D_DATA_WIDTH-1:0] d_rdata,
  output logic                    d_err,
  output logic [31:0]             rd_count,
  output logic [31:0]             wr_count
);
  localparam int IDX_W = (D_MEM_LENGTH > 1) ? $clog2(D_MEM_LENGTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                  state, state_nx;
  logic [7:0]              cnt;
  logic                    wr_q;
  logic [D_ADDR_WIDTH-1:0] addr_q;
  logic [D_DATA_WIDTH-1:0] wdata_q;
  logic                    err_q;

  logic [D_DATA_WIDTH-1:0] mem [D_MEM_LENGTH] = '{default: INIT_VALUE};

  logic                    req_wr;
  logic [7:0]              wait_ld;
  logic                    acc_wr;
  logic [D_ADDR_WIDTH-1:0] acc_addr;
  logic [D_DATA_WIDTH-1:0] acc_wdata;
  logic                    in_range;
  logic [IDX_W-1:0]        idx;
  logic                    done_en;

  assign req_wr  = (d_dir == DIR_WRITE);
  assign wait_ld = req_wr ? 8'(WR_WAIT) : 8'(RD_WAIT);

  // A zero-wait access completes on the sampling edge itself, so take the live bus in IDLE.
  assign acc_wr    = (state == S_IDLE) ? req_wr  : wr_q;
  assign acc_addr  = (state == S_IDLE) ? d_addr  : addr_q;
  assign acc_wdata = (state == S_IDLE) ? d_wdata : wdata_q;
  assign in_range  = 64'(acc_addr) < 64'(D_MEM_LENGTH);
  assign idx       = IDX_W'(acc_addr);
  assign done_en   = (state_nx == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (d_req) state_nx = (wait_ld == 8'd0) ? S_DONE : S_WAIT;
      S_WAIT: begin
        if (!d_req)           state_nx = S_IDLE;
        else if (cnt == 8'd1) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    d_ack = (state == S_DONE);
    d_err = d_ack & err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      d_rdata  <= '0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (state == S_IDLE && d_req) begin
        wr_q    <= req_wr;
        addr_q  <= d_addr;
        wdata_q <= d_wdata;
        cnt     <= wait_ld;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 8'd1;
      end
      if (done_en) begin
        err_q <= !in_range;
        if (acc_wr) begin
          wr_count <= wr_count + 32'd1;
        end else begin
          rd_count <= rd_count + 32'd1;
          d_rdata  <= in_range ? mem[idx] : '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && done_en && acc_wr && in_range) mem[idx] <= acc_wdata;
  end
endmodule
